gate_result_checker: RTL

Downstream self-check stage for the basic-gate block. It consumes the same `a`/`b` stimulus as the gate block, along with the gate block's seven outputs `t`..`z`. It compares each output against a golden model and counts vectors and mismatches over a run of `NUM_VEC` accepted vectors. At the end of the run it reports pass/fail, plus the index and mask of the first failing vector.

---
 rtl/gate_result_checker_pkg.sv | 39 +++
 rtl/gate_result_checker_if.sv | 45 ++++
 rtl/gate_result_checker_golden.sv | 27 ++
 rtl/gate_result_checker.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/gate_result_checker_pkg.sv
// -----------------------------------------------------------------------------
// gate_chk_pkg
// Shared definitions for the gate result checker:
//   - FSM state enumeration (IDLE / RUN / DONE)
//   - GATE_W: number of gate outputs under test
//   - T_BIT..Z_BIT: bit position of each gate output in a 7-bit vector
//   - MISR_SEED and the MISR next-state helper (used when GATE_CHK_MISR_EN
//     is defined)
// -----------------------------------------------------------------------------
package gate_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } gate_chk_state_e;

    localparam int GATE_W = 7;

    localparam int T_BIT = 0;   // a & b
    localparam int U_BIT = 1;   // a | b
    localparam int V_BIT = 2;   // ~(a & b)
    localparam int W_BIT = 3;   // ~(a | b)
    localparam int X_BIT = 4;   // a ^ b
    localparam int Y_BIT = 5;   // ~(a ^ b)
    localparam int Z_BIT = 6;   // ~a

    localparam logic [7:0] MISR_SEED = 8'hFF;

    // One MISR step: shift with feedback taps 7,5,4,3, then fold in the
    // gate outputs on the low seven bits.
    function automatic logic [7:0] misr_step(input logic [7:0] s,
                                             input logic [GATE_W-1:0] d);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[6:0], fb} ^ {1'b0, d};
    endfunction

endpackage

// File: rtl/gate_result_checker_if.sv
// -----------------------------------------------------------------------------
// gate_result_checker_if
// Bundles the stimulus, the gate outputs under test and the checker results.
//   master : drives start/in_valid/a/b/t..z, observes results
//   slave  : the checker itself
// Parameter CNT_W sets the width of vec_cnt, err_cnt and first_err_idx.
// -----------------------------------------------------------------------------
interface gate_result_checker_if
    import gate_chk_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic              start;
    logic              in_valid;
    logic              a;
    logic              b;
    logic              t;
    logic              u;
    logic              v;
    logic              w;
    logic              x;
    logic              y;
    logic              z;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  vec_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  first_err_idx;
    logic [GATE_W-1:0] first_err_mask;
    logic [7:0]        signature;

    modport master (
        output start, in_valid, a, b, t, u, v, w, x, y, z,
        input  busy, done, pass, vec_cnt, err_cnt,
               first_err_idx, first_err_mask, signature
    );

    modport slave (
        input  start, in_valid, a, b, t, u, v, w, x, y, z,
        output busy, done, pass, vec_cnt, err_cnt,
               first_err_idx, first_err_mask, signature
    );

endinterface

// File: rtl/gate_result_checker_golden.sv
// -----------------------------------------------------------------------------
// gate_golden_model
// Purely combinational reference for the basic-gate block.
//   i_a, i_b    : stimulus bits
//   o_expected  : expected gate outputs, bit T_BIT (a&b) .. Z_BIT (~a)
// -----------------------------------------------------------------------------
module gate_golden_model
    import gate_chk_pkg::*;
(
    input  logic              i_a,
    input  logic              i_b,
    output logic [GATE_W-1:0] o_expected
);

    // Fixed gate mapping
    always_comb begin
        o_expected        = {GATE_W{1'b0}};
        o_expected[T_BIT] = i_a & i_b;
        o_expected[U_BIT] = i_a | i_b;
        o_expected[V_BIT] = ~(i_a & i_b);
        o_expected[W_BIT] = ~(i_a | i_b);
        o_expected[X_BIT] = i_a ^ i_b;
        o_expected[Y_BIT] = ~(i_a ^ i_b);
        o_expected[Z_BIT] = ~i_a;
    end

endmodule

// File: rtl/gate_result_checker.sv
// -----------------------------------------------------------------------------
// gate_result_checker
// Self-check stage for the basic-gate block. Over a run of NUM_VEC accepted
// vectors it compares t..z against the golden model, counts vectors and
// failures, and records index/mask of the first failing vector.
//
// Parameters:
//   NUM_VEC : vectors per run (1 .. 2^CNT_W-1)
//   CNT_W   : width of counters and first_err_idx
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   bus     : gate_result_checker_if.slave (start, in_valid, a, b, t..z in;
//             busy, done, pass, vec_cnt, err_cnt, first_err_idx,
//             first_err_mask, signature out)
// Configuration macro:
//   GATE_CHK_MISR_EN : builds an 8-bit MISR over the gate outputs; when
//                      undefined, signature is tied to 8'h00.
// -----------------------------------------------------------------------------
module gate_result_checker
    import gate_chk_pkg::*;
#(
    parameter int NUM_VEC = 16,
    parameter int CNT_W   = 8
)(
    input  logic                  clk,
    input  logic                  rst,
    gate_result_checker_if.slave  bus
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VEC);

    logic [1:0]        r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [CNT_W-1:0]  r_vec_cnt;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [CNT_W-1:0]  r_first_err_idx;
    logic [GATE_W-1:0] r_first_err_mask;

    logic [GATE_W-1:0] w_expected;
    logic [GATE_W-1:0] w_actual;
    logic [GATE_W-1:0] w_mask;
    logic              w_fail;
    logic              w_accept;
    logic              w_last_vec;
    logic              w_first_fail;
    logic              w_start_ok;
    logic [CNT_W-1:0]  w_vec_inc;
    logic [CNT_W-1:0]  w_err_upd;

    gate_golden_model u_golden (
        .i_a        (bus.a),
        .i_b        (bus.b),
        .o_expected (w_expected)
    );

    // Compare, accept and next-count decode for the current cycle
    always_comb begin
        w_actual     = {bus.z, bus.y, bus.x, bus.w, bus.v, bus.u, bus.t};
        w_mask       = w_actual ^ w_expected;
        w_fail       = (w_mask != {GATE_W{1'b0}});
        w_accept     = (r_state == S_RUN) && bus.in_valid;
        w_start_ok   = (r_state == S_IDLE) && bus.start;
        w_vec_inc    = r_vec_cnt + CNT_ONE;
        w_last_vec   = (w_vec_inc == NUM_VEC_C);
        // err_cnt never wraps back to zero, so zero means "no failure yet"
        w_first_fail = w_fail && (r_err_cnt == CNT_ZERO);
        if (!w_fail) begin
            w_err_upd = r_err_cnt;
        end else if (r_err_cnt == CNT_MAX) begin
            w_err_upd = r_err_cnt;
        end else begin
            w_err_upd = r_err_cnt + CNT_ONE;
        end
    end

    // Run-control FSM with counters and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_vec_cnt        <= CNT_ZERO;
            r_err_cnt        <= CNT_ZERO;
            r_first_err_idx  <= CNT_ZERO;
            r_first_err_mask <= {GATE_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_start_ok) begin
                        r_state          <= S_RUN;
                        r_busy           <= 1'b1;
                        r_pass           <= 1'b0;
                        r_vec_cnt        <= CNT_ZERO;
                        r_err_cnt        <= CNT_ZERO;
                        r_first_err_idx  <= CNT_ZERO;
                        r_first_err_mask <= {GATE_W{1'b0}};
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_vec_cnt <= w_vec_inc;
                        r_err_cnt <= w_err_upd;
                        if (w_first_fail) begin
                            r_first_err_idx  <= r_vec_cnt;
                            r_first_err_mask <= w_mask;
                        end else begin
                            r_first_err_idx  <= r_first_err_idx;
                        end
                        if (w_last_vec) begin
                            // busy falls and pass is captured on the edge
                            // that takes the final vector
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_upd == CNT_ZERO);
                        end else begin
                            r_state <= S_RUN;
                        end
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.pass           = r_pass;
    assign bus.vec_cnt        = r_vec_cnt;
    assign bus.err_cnt        = r_err_cnt;
    assign bus.first_err_idx  = r_first_err_idx;
    assign bus.first_err_mask = r_first_err_mask;

`ifdef GATE_CHK_MISR_EN
    logic [7:0] r_signature;

    // Output signature: seeded on an accepted start, stepped per vector
    always_ff @(posedge clk) begin
        if (rst) begin
            r_signature <= 8'h00;
        end else if (w_start_ok) begin
            r_signature <= MISR_SEED;
        end else if (w_accept) begin
            r_signature <= misr_step(r_signature, w_actual);
        end else begin
            r_signature <= r_signature;
        end
    end

    assign bus.signature = r_signature;
`else
    assign bus.signature = 8'h00;
`endif

endmodule
